// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and transmit FSM state encoding, used by
//               both the transmit and the receive paths.
//               Contents: CLOCKS_PER_BIT (default bit period in clocks),
//               FIFO_DEPTH (default transmit buffer depth), tx_state_e.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 50 MHz system clock / 9600 bps
    localparam int CLOCKS_PER_BIT = 5208;
    // Transmit buffer entries; must be a power of two and at least 2
    localparam int FIFO_DEPTH     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding the UART serializer. Pointers wrap modulo
//               DEPTH; a write is taken only when the FIFO was not full at the
//               edge, so a pop on the same edge never makes room for it.
// Ports       : clk        - system clock
//               reset      - asynchronous active-low reset
//               wr_i       - write strobe
//               wr_data_i  - byte to write at the tail
//               pop_i      - remove the head entry
//               full_o     - DEPTH entries stored
//               empty_o    - no entries stored
//               head_o     - byte at the head
//               count_o    - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = uart_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          wr_en;
    logic          pop_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Full is the registered status, so a concurrent pop cannot admit a write.
    assign wr_en  = wr_i && !full_o;
    assign pop_en = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;   // natural wrap: DEPTH is a power of two
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Buffered 8N1 UART transmitter. Bytes are queued in
//               uart_tx_fifo and serialized start/LSB-first data/stop, each
//               bit CLOCKS_PER_BIT cycles; queued frames follow back-to-back.
// Ports       : clk       - system clock
//               reset     - asynchronous active-low reset
//               tx_data   - byte to enqueue
//               tx_wr     - enqueue strobe
//               tx_full   - transmit buffer full
//               tx_busy   - buffer non-empty or frame in progress
//               tx_done   - one-cycle pulse in the last cycle of a stop bit
//               uart_txd  - registered serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLOCKS_PER_BIT = uart_pkg::CLOCKS_PER_BIT,
    parameter int FIFO_DEPTH     = uart_pkg::FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);
    import uart_pkg::*;

    localparam int             CW       = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BIT_LAST = CW'(CLOCKS_PER_BIT - 1);

    tx_state_e                 state_q, state_d;
    logic [CW-1:0]             cnt_q,   cnt_d;
    logic [2:0]                idx_q,   idx_d;
    logic [7:0]                shift_q, shift_d;
    logic                      txd_q,   txd_d;

    logic                      fifo_pop;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [7:0]                fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_i      (tx_wr),
        .wr_data_i (tx_data),
        .pop_i     (fifo_pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .count_o   (fifo_count)
    );

    assign bit_end = (cnt_q == BIT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line register follows the next state so it changes on the same
        // edge as the FSM: a pop from IDLE drives the start bit immediately.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[idx_d];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_full  = fifo_full;
    assign tx_busy  = (state_q != ST_IDLE) || (fifo_count != '0);
    assign tx_done  = (state_q == ST_STOP) && bit_end;

endmodule
`default_nettype wire
